// File: rtl/req_ack_gen.sv
// -----------------------------------------------------------------------------
// req_ack_gen
//
// Purpose:
//   Turns each accepted request (valid=1, a=1, flush=0 at a clock edge) into a
//   single registered ack pulse on b, DELAY cycles later. Requests are fully
//   pipelined, so back-to-back requests give back-to-back acks. A qualified
//   sample with a=0 is a protocol violation and gives a one-cycle err pulse on
//   the next cycle. flush drops every in-flight request.
//
// Parameters:
//   DELAY  cycles from sampled request to sampled ack (legal 1..8)
//   CNT_W  width of the optional statistics counters
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset (wins over flush and requests)
//   valid    in   qualifier; a is only looked at when valid=1
//   a        in   request
//   flush    in   synchronous clear of all in-flight requests
//   b        out  registered ack, one pulse per accepted request
//   busy     out  at least one accepted request still awaits its ack
//   err      out  registered one-cycle pulse after a valid=1, a=0 sample
//   req_cnt  out  accepted-request count  (REQ_ACK_STATS_EN only)
//   ack_cnt  out  issued-ack count        (REQ_ACK_STATS_EN only)
//
// Configuration:
//   Define REQ_ACK_STATS_EN to compile in req_cnt/ack_cnt and their counters.
// -----------------------------------------------------------------------------
module req_ack_gen #(
  parameter int DELAY = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             a,
  input  logic             flush,
  output logic             b,
  output logic             busy,
`ifdef REQ_ACK_STATS_EN
  output logic [CNT_W-1:0] req_cnt,
  output logic [CNT_W-1:0] ack_cnt,
`endif
  output logic             err
);

  // A request is only taken when it is qualified and not killed by a
  // simultaneous flush.
  logic accept;
  assign accept = valid & a & ~flush;

  generate
    if (DELAY == 1) begin : g_direct
      // With no pipeline stages the ack register is loaded straight from the
      // acceptance condition; flush clears it on the same edge.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          b <= 1'b0;
        end else begin
          b <= accept;
        end
      end

      assign busy = b;
    end else begin : g_pipe
      // DELAY-1 stages in front of the ack register give DELAY edges of
      // latency. Clearing b together with the stages on flush also drops the
      // ack that would otherwise have been loaded on the flush edge.
      logic [DELAY-2:0] stages;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          stages <= '0;
          b      <= 1'b0;
        end else begin
          stages[0] <= accept;
          for (int i = 1; i < DELAY - 1; i++) begin
            stages[i] <= stages[i-1];
          end
          b <= stages[DELAY-2];
        end
      end

      // Built only from registers, so busy has no path from the inputs.
      assign busy = (|stages) | b;
    end
  endgenerate

  // err looks at valid and a only, so a violation is still flagged on a
  // flush edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= valid & ~a;
    end
  end

`ifdef REQ_ACK_STATS_EN
  // Free-running statistics that wrap modulo 2^CNT_W. ack_cnt counts the
  // registered b, so it lags the corresponding ack by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_cnt <= '0;
      ack_cnt <= '0;
    end else begin
      if (accept) begin
        req_cnt <= req_cnt + CNT_W'(1);
      end
      if (b) begin
        ack_cnt <= ack_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
